// File: rtl/lock_supervisor.sv
// Supervisor downstream of the serial-code lock FSM: timed door release,
// consecutive-failure counting and a timed lockout with siren.
module lock_supervisor #(
  parameter int unsigned UNLOCK_CYCLES  = 8,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned FAIL_W         = 2,
  parameter int unsigned TMR_W          = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock_ok,
  input  logic              alarm_in,
  input  logic              clear,
  output logic              door_open,
  output logic              siren,
  output logic              lockout,
  output logic [FAIL_W-1:0] fail_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0]  UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO     = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE      = TMR_W'(1);
  localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0] FAIL_ZERO    = {FAIL_W{1'b0}};
  localparam logic [FAIL_W-1:0] FAIL_ONE     = FAIL_W'(1);

  // Saturating increment so the counter can never pass MAX_FAILS or wrap.
  function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] cnt);
    logic [FAIL_W-1:0] res;
    if (cnt >= FAIL_MAX) begin
      res = FAIL_MAX;
    end else begin
      res = cnt + FAIL_ONE;
    end
    return res;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [TMR_W-1:0]  timer_r, timer_nxt_s;
  logic [FAIL_W-1:0] fail_r, fail_nxt_s;
  logic [FAIL_W-1:0] fail_up_s;
  logic              hit_max_s;
  logic              door_open_r, siren_r, lockout_r;

  // Next-state, timer and counter logic; clear outranks alarm_in outranks lock_ok.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    fail_nxt_s  = fail_r;
    fail_up_s   = fail_inc(fail_r);
    hit_max_s   = (fail_up_s == FAIL_MAX);
    if (clear) begin
      state_nxt_s = IDLE;
      timer_nxt_s = TMR_ZERO;
      fail_nxt_s  = FAIL_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (alarm_in) begin
            fail_nxt_s = fail_up_s;
            if (hit_max_s) begin
              state_nxt_s = LOCKOUT;
              timer_nxt_s = LOCKOUT_LOAD;
            end else begin
              state_nxt_s = IDLE;
            end
          end else if (lock_ok) begin
            state_nxt_s = OPEN;
            timer_nxt_s = UNLOCK_LOAD;
            fail_nxt_s  = FAIL_ZERO;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        OPEN: begin
          if (alarm_in) begin
            fail_nxt_s = fail_up_s;
            if (hit_max_s) begin
              state_nxt_s = LOCKOUT;
              timer_nxt_s = LOCKOUT_LOAD;
            end else begin
              state_nxt_s = IDLE;
              timer_nxt_s = TMR_ZERO;
            end
          end else if (lock_ok) begin
            // Retrigger wins over expiry so door_open has no gap.
            timer_nxt_s = UNLOCK_LOAD;
          end else if (timer_r == TMR_ZERO) begin
            state_nxt_s = IDLE;
          end else begin
            timer_nxt_s = timer_r - TMR_ONE;
          end
        end
        LOCKOUT: begin
          if (timer_r == TMR_ZERO) begin
            state_nxt_s = IDLE;
            fail_nxt_s  = FAIL_ZERO;
          end else begin
            timer_nxt_s = timer_r - TMR_ONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          timer_nxt_s = TMR_ZERO;
          fail_nxt_s  = FAIL_ZERO;
        end
      endcase
    end
  end

  // State, timer, counter and outputs, all registered from next-state values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      timer_r     <= TMR_ZERO;
      fail_r      <= FAIL_ZERO;
      door_open_r <= 1'b0;
      siren_r     <= 1'b0;
      lockout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      fail_r      <= fail_nxt_s;
      door_open_r <= (state_nxt_s == OPEN);
      siren_r     <= (state_nxt_s == LOCKOUT);
      lockout_r   <= (state_nxt_s == LOCKOUT);
    end
  end

  assign door_open  = door_open_r;
  assign siren      = siren_r;
  assign lockout    = lockout_r;
  assign fail_count = fail_r;

endmodule

// File: doc/lock_supervisor.md
# lock_supervisor

Registered supervisor that sits directly downstream of the serial-code electric lock FSM. It consumes that FSM's `lockSys` (code accepted) and `alarm` (code rejected) outputs on the same clock. It turns them into a timed door-release pulse, a failed-attempt counter, and a timed lockout with siren. During lockout all lock events are ignored until the lockout timer expires or an administrator clear is applied.

## Interface
- `UNLOCK_CYCLES`, default 8: number of cycles `door_open` is held high per accepted code (≥1).
- `MAX_FAILS`, default 3: consecutive rejected codes that trigger lockout (1 ≤ MAX_FAILS ≤ 2^FAIL_W − 1).
- `LOCKOUT_CYCLES`, default 16: number of cycles lockout/siren is held (≥1).
- `FAIL_W`, default 2: width of `fail_count`.
- `TMR_W`, default 5: timer width; must hold max(UNLOCK_CYCLES, LOCKOUT_CYCLES).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `lock_ok` input 1: from lock FSM `lockSys`; sampled at each rising edge.
- `alarm_in` input 1: from lock FSM `alarm`; sampled at each rising edge.
- `clear` input 1: administrator clear; synchronous, highest priority after reset.
- `door_open` output 1: door release, registered.
- `siren` output 1: alarm sounder, registered.
- `lockout` output 1: high while in LOCKOUT, registered.
- `fail_count` output FAIL_W: consecutive rejected attempts, registered.

## Operation
- Reset (`reset`=0, asynchronous): state=IDLE, timer=0, `door_open`=0, `siren`=0, `lockout`=0, `fail_count`=0. These values apply immediately, with no clock edge required.
- Inputs are sampled only at clock edges. Combinational glitches from the upstream Mealy outputs between edges have no effect.
- Priority at each edge: `clear` > `alarm_in` > `lock_ok`.
- `clear`=1 in any state: next state IDLE, `fail_count`=0, timer=0, all outputs 0.
- **IDLE**
  - `alarm_in`=1: `fail_count` increments.
    - If the new value equals MAX_FAILS: go to LOCKOUT and load timer=LOCKOUT_CYCLES−1.
    - Otherwise: stay in IDLE.
  - `lock_ok`=1 (and `alarm_in`=0): go to OPEN, load timer=UNLOCK_CYCLES−1, set `fail_count`=0.
- **OPEN** (`door_open`=1)
  - Timer decrements each cycle. When the timer is 0, go to IDLE.
  - `lock_ok`=1: reload timer=UNLOCK_CYCLES−1 (retrigger, no gap in `door_open`).
  - `alarm_in`=1: abort to IDLE (`door_open` drops) and increment `fail_count`, with the same lockout check as IDLE.
- **LOCKOUT** (`lockout`=1, `siren`=1, `door_open`=0)
  - `lock_ok` and `alarm_in` are ignored.
  - Timer decrements each cycle. When the timer is 0, go to IDLE with `fail_count`=0.
- `fail_count` never exceeds MAX_FAILS and never wraps.
- Simultaneous `lock_ok` and `alarm_in`: treated as `alarm_in` only.

## Timing
- All outputs are registered. Event sampled at edge N → output change visible after edge N.
- Accepted code: `door_open` is high for exactly UNLOCK_CYCLES cycles (edges N+1 … N+UNLOCK_CYCLES inclusive, measured as state), then low.
- Lockout: `lockout`/`siren` are high for exactly LOCKOUT_CYCLES cycles, starting after the edge that sampled the final failing `alarm_in`.
- Lockout expiry: outputs clear together with `fail_count` reset, all on the same edge.
- Reset asserted mid-OPEN or mid-LOCKOUT: outputs go to 0 asynchronously. After `reset` deasserts, the first edge evaluates from IDLE.
- `clear` takes effect on the edge where it is sampled high; outputs are 0 from the next cycle.

## Test plan
- **Reset**: hold `reset`=0 in mid-LOCKOUT (`siren`=1) → all outputs 0 without a clock edge; after release, `lock_ok` pulse → `door_open`=1 for 8 cycles.
- **Unlock with retrigger**: `lock_ok` 1-cycle pulse → `door_open` high for exactly 8 cycles. A second pulse at cycle 5 → `door_open` stays high until 8 cycles after the second pulse, `fail_count`=0 throughout.
- **Lockout entry and expiry**: three `alarm_in` pulses spaced 3 cycles apart → `fail_count` goes 1, 2, then `lockout`=`siren`=1 for exactly 16 cycles. `lock_ok` pulses during lockout → ignored (`door_open`=0). At expiry `fail_count`=0.
- **Counter reset on success**: `alarm_in`, `alarm_in`, `lock_ok`, `alarm_in` → `fail_count` goes 1, 2, 0, 1, and no lockout occurs.
- **Abort and simultaneity**: during OPEN, `alarm_in`=1 → `door_open` drops the next cycle and `fail_count`=1. In IDLE, `lock_ok`=`alarm_in`=1 on the same edge → no door release and `fail_count` increments.
- **Admin clear**: `clear`=1 at cycle 4 of LOCKOUT → `lockout`=`siren`=0 and `fail_count`=0 the next cycle; a subsequent `lock_ok` is accepted normally.
